// File: rtl/dahb_sram_slave_if.sv
// AHB-lite bus bundle between a data master and the SRAM slave responder.
// The master modport also drives HREADY, standing in for the fabric's ready mux.
interface dahb_sram_slave_if;
    logic        HSEL;
    logic        HREADY;
    logic [1:0]  HTRANS;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;

    modport master (
        output HSEL, HREADY, HTRANS, HADDR, HWRITE, HSIZE, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HREADY, HTRANS, HADDR, HWRITE, HSIZE, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/dahb_sram_slave.sv
// AHB slave backed by a word-addressed SRAM split into four byte lanes, with
// programmable wait states, two-cycle ERROR response and write-to-read forwarding.
module dahb_sram_slave #(
    parameter int          MEM_AW      = 10,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    dahb_sram_slave_if.slave   io_bus
);
    localparam int         DEPTH     = 1 << MEM_AW;
    localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t            r_state;
    logic [2:0]        r_wcnt;
    logic              r_hreadyout;
    logic [1:0]        r_hresp;
    logic [MEM_AW-1:0] r_idx;
    logic [1:0]        r_lo;
    logic [1:0]        r_size;
    logic              r_write;

    logic [31:0]       w_off;
    logic [MEM_AW-1:0] w_idx;
    logic              w_accept;
    logic              w_can;
    logic              w_take;
    logic              w_in_range;
    logic              w_aligned;
    logic              w_legal;
    logic              w_we;
    logic              w_fwd;
    logic [3:0]        w_lane_en;
    logic [31:0]       w_rdata;

    assign w_off      = io_bus.HADDR - BASE_ADDR;
    assign w_idx      = w_off[MEM_AW+1:2];
    assign w_accept   = io_bus.HSEL & io_bus.HREADY &
                        ((io_bus.HTRANS == 2'b10) | (io_bus.HTRANS == 2'b11));
    // Address phases are only taken when our own data phase is finishing or absent.
    assign w_can      = (r_state == S_IDLE) | (r_state == S_ERR2) |
                        ((r_state == S_DATA) & (r_wcnt == 3'd0));
    assign w_take     = w_accept & w_can;
    assign w_in_range = (w_off >> (MEM_AW + 2)) == 32'd0;

    always_comb begin
        w_aligned = 1'b0;
        case (io_bus.HSIZE)
            3'd0:    w_aligned = 1'b1;
            3'd1:    w_aligned = ~io_bus.HADDR[0];
            3'd2:    w_aligned = (io_bus.HADDR[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    assign w_legal = w_in_range & w_aligned;
    assign w_we    = (r_state == S_DATA) & (r_wcnt == 3'd0) & r_write;
    assign w_fwd   = w_we & (r_idx == w_idx);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_rdata_b;

            assign w_lane_en[gi] = (r_size == 2'd2) |
                                   ((r_size == 2'd1) & (r_lo[1] == LANE[1])) |
                                   ((r_size == 2'd0) & (r_lo == LANE));

            // A read taken on the edge a write to the same word commits sees the new lanes.
            always_ff @(posedge HCLK) begin
                if (w_we && w_lane_en[gi])
                    r_mem[r_idx] <= io_bus.HWDATA[8*gi +: 8];
                if (w_take)
                    r_rdata_b <= (w_fwd && w_lane_en[gi]) ? io_bus.HWDATA[8*gi +: 8]
                                                          : r_mem[w_idx];
            end

            assign w_rdata[8*gi +: 8] = r_rdata_b;
        end
    endgenerate

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= S_IDLE;
            r_wcnt      <= 3'd0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 2'b00;
            r_idx       <= '0;
            r_lo        <= 2'b00;
            r_size      <= 2'b00;
            r_write     <= 1'b0;
        end else if ((r_state == S_DATA) && (r_wcnt != 3'd0)) begin
            r_wcnt      <= r_wcnt - 3'd1;
            r_hreadyout <= (r_wcnt == 3'd1);
        end else if (r_state == S_ERR1) begin
            r_state     <= S_ERR2;
            r_hreadyout <= 1'b1;
            r_hresp     <= 2'b01;
        end else if (w_take) begin
            if (w_legal) begin
                r_state     <= S_DATA;
                r_wcnt      <= WAIT_INIT;
                r_hreadyout <= (WAIT_INIT == 3'd0);
                r_hresp     <= 2'b00;
                r_idx       <= w_idx;
                r_lo        <= io_bus.HADDR[1:0];
                r_size      <= io_bus.HSIZE[1:0];
                r_write     <= io_bus.HWRITE;
            end else begin
                r_state     <= S_ERR1;
                r_hreadyout <= 1'b0;
                r_hresp     <= 2'b01;
                r_write     <= 1'b0;
            end
        end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 2'b00;
        end
    end

    assign io_bus.HREADYOUT = r_hreadyout;
    assign io_bus.HRESP     = r_hresp;
    assign io_bus.HRDATA    = (r_state == S_DATA) ? w_rdata : 32'd0;
endmodule
